// File: rtl/rpc_cmd_pkg.sv
// rtl/rpc_cmd_pkg.sv - shared split tags and command record for the RPC command path
package rpc_cmd_pkg;

  localparam logic [1:0] SPLIT_NONE   = 2'b00;
  localparam logic [1:0] SPLIT_FIRST  = 2'b01;
  localparam logic [1:0] SPLIT_SECOND = 2'b10;

  localparam int CMD_ADDR_W = 27;
  localparam int CMD_LEN_W  = 7;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
    logic                  write;
    logic [1:0]            split_req;
  } rpc_cmd_t;

endpackage

// File: rtl/rpc_page_split_calc.sv
// rtl/rpc_page_split_calc.sv - combinational page-boundary split of one command
module rpc_page_split_calc #(
  parameter int AddrWidth = 27,
  parameter int PageWords = 64,
  parameter int LenWidth  = $clog2(PageWords) + 1
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [LenWidth-1:0]  len_i,
  output logic                 is_split_o,
  output logic [AddrWidth-1:0] first_addr_o,
  output logic [LenWidth-1:0]  first_len_o,
  output logic [AddrWidth-1:0] second_addr_o,
  output logic [LenWidth-1:0]  second_len_o
);

  localparam int OffWidth = $clog2(PageWords);
  localparam logic [LenWidth:0]   PAGE_END   = (LenWidth + 1)'(PageWords);
  localparam logic [LenWidth-1:0] PAGE_WORDS = LenWidth'(PageWords);

  logic [LenWidth-1:0] off;
  logic [LenWidth:0]   end_pos;
  logic [LenWidth-1:0] head;

  // One extra bit on end_pos so off + len can never wrap.
  assign off     = LenWidth'(addr_i[OffWidth-1:0]);
  assign end_pos = {1'b0, off} + {1'b0, len_i};
  assign head    = PAGE_WORDS - off;

  assign is_split_o    = end_pos > PAGE_END;
  assign first_addr_o  = addr_i;
  assign first_len_o   = is_split_o ? head : len_i;
  // Second piece starts on the next page boundary; address wraps naturally.
  assign second_addr_o = addr_i + AddrWidth'(head);
  assign second_len_o  = len_i - head;

endmodule

// File: rtl/rpc_cmd_page_splitter.sv
// rtl/rpc_cmd_page_splitter.sv - splits page-crossing commands into two tagged pieces
module rpc_cmd_page_splitter
  import rpc_cmd_pkg::*;
#(
  parameter int AddrWidth = 27,
  parameter int PageWords = 64,
  parameter int LenWidth  = $clog2(PageWords) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LenWidth-1:0]  cmd_len_i,
  input  logic                 cmd_write_i,
  output logic                 cmd_valid_o,
  input  logic                 cmd_ready_i,
  output logic [AddrWidth-1:0] cmd_addr_o,
  output logic [LenWidth-1:0]  cmd_len_o,
  output logic                 cmd_write_o,
  output logic [1:0]           split_req_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SINGLE = 2'd1;
  localparam logic [1:0] ST_FIRST  = 2'd2;

  logic [1:0]           state;
  logic [AddrWidth-1:0] pend_addr;
  logic [LenWidth-1:0]  pend_len;
  logic                 accept;

  logic                 is_split;
  logic [AddrWidth-1:0] first_addr;
  logic [LenWidth-1:0]  first_len;
  logic [AddrWidth-1:0] second_addr;
  logic [LenWidth-1:0]  second_len;

  rpc_page_split_calc #(
    .AddrWidth (AddrWidth),
    .PageWords (PageWords),
    .LenWidth  (LenWidth)
  ) u_calc (
    .addr_i        (cmd_addr_i),
    .len_i         (cmd_len_i),
    .is_split_o    (is_split),
    .first_addr_o  (first_addr),
    .first_len_o   (first_len),
    .second_addr_o (second_addr),
    .second_len_o  (second_len)
  );

  // A new command may enter when empty, or when the last held piece leaves this cycle.
  assign cmd_ready_o = rst_ni && ((state == ST_IDLE) || ((state == ST_SINGLE) && cmd_ready_i));
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign cmd_valid_o = (state != ST_IDLE);

  // Output/pending registers and state advance only on accept or downstream handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      cmd_addr_o  <= '0;
      cmd_len_o   <= '0;
      cmd_write_o <= 1'b0;
      split_req_o <= SPLIT_NONE;
      pend_addr   <= '0;
      pend_len    <= '0;
    end else if (accept) begin
      cmd_addr_o  <= first_addr;
      cmd_len_o   <= first_len;
      cmd_write_o <= cmd_write_i;
      split_req_o <= is_split ? SPLIT_FIRST : SPLIT_NONE;
      pend_addr   <= second_addr;
      pend_len    <= second_len;
      state       <= is_split ? ST_FIRST : ST_SINGLE;
    end else if ((state == ST_FIRST) && cmd_ready_i) begin
      cmd_addr_o  <= pend_addr;
      cmd_len_o   <= pend_len;
      split_req_o <= SPLIT_SECOND;
      state       <= ST_SINGLE;
    end else if ((state == ST_SINGLE) && cmd_ready_i) begin
      state       <= ST_IDLE;
    end
  end

  // Zero-length commands are illegal upstream; flag them in simulation.
  len_nonzero_a: assert property (@(posedge clk_i) disable iff (!rst_ni) accept |-> (cmd_len_i != '0));

endmodule

// File: tb/tb_rpc_cmd_page_splitter.sv
// tb/tb_rpc_cmd_page_splitter.sv - self-checking bench for rpc_cmd_page_splitter
module tb_rpc_cmd_page_splitter;
  import rpc_cmd_pkg::*;

  localparam int AW = 27;
  localparam int PW = 64;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic          cmd_write_i;
  logic          cmd_valid_o;
  logic          cmd_ready_i;
  logic [AW-1:0] cmd_addr_o;
  logic [LW-1:0] cmd_len_o;
  logic          cmd_write_o;
  logic [1:0]    split_req_o;

  always #5 clk = ~clk;

  rpc_cmd_page_splitter #(.AddrWidth(AW), .PageWords(PW), .LenWidth(LW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_write_i (cmd_write_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_addr_o  (cmd_addr_o),
    .cmd_len_o   (cmd_len_o),
    .cmd_write_o (cmd_write_o),
    .split_req_o (split_req_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          write;
    int            n;
    rpc_cmd_t      p0;
    rpc_cmd_t      p1;
  } vec_t;

  int       total = 0;
  int       bad   = 0;
  rpc_cmd_t exp_q[$];
  rpc_cmd_t staged[$];
  bit       rand_ready = 1'b0;
  bit       prev_stall = 1'b0;
  rpc_cmd_t prev_out;
  bit       accepted;
  vec_t     vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic rpc_cmd_t mk(input longint a, input int l, input bit w, input logic [1:0] s);
    rpc_cmd_t c;
    c.addr      = AW'(a);
    c.len       = LW'(l);
    c.write     = w;
    c.split_req = s;
    return c;
  endfunction

  // Reference: pieces of one command from plain page arithmetic.
  task automatic model(input longint addr, input int len, input bit w);
    longint off;
    longint head;
    staged.delete();
    off = addr % PW;
    if (off + len > PW) begin
      head = PW - off;
      staged.push_back(mk(addr, int'(head), w, 2'b01));
      staged.push_back(mk((addr + head) % (longint'(1) << AW), len - int'(head), w, 2'b10));
    end else begin
      staged.push_back(mk(addr, len, w, 2'b00));
    end
  endtask

  // One clock: sample 1ns before the edge, score outputs, record accepts.
  task automatic tick();
    rpc_cmd_t cur;
    if (rand_ready) cmd_ready_i = ($urandom_range(0, 3) != 0);
    #4;
    cur = mk(longint'(cmd_addr_o), int'(cmd_len_o), cmd_write_o, split_req_o);
    check("valid_o", 64'(cmd_valid_o), 64'(exp_q.size() != 0));
    check("ready_o", 64'(cmd_ready_o),
          64'((exp_q.size() == 0) || (exp_q.size() == 1 && cmd_ready_i)));
    if (prev_stall) check("hold_stable", 64'(cur), 64'(prev_out));
    prev_stall = cmd_valid_o && !cmd_ready_i;
    prev_out   = cur;
    if (cmd_valid_o && cmd_ready_i && exp_q.size() != 0) begin
      check("piece", 64'(cur), 64'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    accepted = cmd_valid_i && cmd_ready_o;
    if (accepted) foreach (staged[i]) exp_q.push_back(staged[i]);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input longint a, input int l, input bit w, output int tries);
    cmd_valid_i = 1'b1;
    cmd_addr_i  = AW'(a);
    cmd_len_i   = LW'(l);
    cmd_write_i = w;
    tries = 0;
    do begin
      tick();
      tries++;
    end while (!accepted && tries < 20);
    check("accepted", 64'(accepted), 64'd1);
  endtask

  task automatic idle(input int n);
    cmd_valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int guard;
    cmd_valid_i = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check("drained", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    int tries;
    longint a;
    int l;

    vt[0] = '{27'h010, 7'd8, 1'b0, 1, mk(27'h010, 8, 0, 2'b00), mk(0, 0, 0, 2'b00)};
    vt[1] = '{27'h03C, 7'd8, 1'b0, 2, mk(27'h03C, 4, 0, 2'b01), mk(27'h040, 4, 0, 2'b10)};
    vt[2] = '{27'h000, 7'd64, 1'b1, 1, mk(27'h000, 64, 1, 2'b00), mk(0, 0, 0, 2'b00)};
    vt[3] = '{27'h7FF, 7'd2, 1'b0, 2, mk(27'h7FF, 1, 0, 2'b01), mk(27'h800, 1, 0, 2'b10)};
    vt[4] = '{27'h03F, 7'd1, 1'b1, 1, mk(27'h03F, 1, 1, 2'b00), mk(0, 0, 0, 2'b00)};
    vt[5] = '{27'h001, 7'd64, 1'b0, 2, mk(27'h001, 63, 0, 2'b01), mk(27'h040, 1, 0, 2'b10)};
    vt[6] = '{27'h7FFFFFF, 7'd2, 1'b1, 2, mk(27'h7FFFFFF, 1, 1, 2'b01), mk(27'h0000000, 1, 1, 2'b10)};
    vt[7] = '{27'h020, 7'd32, 1'b1, 1, mk(27'h020, 32, 1, 2'b00), mk(0, 0, 0, 2'b00)};
    vt[8] = '{27'h020, 7'd33, 1'b1, 2, mk(27'h020, 32, 1, 2'b01), mk(27'h040, 1, 1, 2'b10)};

    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_ready_i = 1'b0;
    cmd_addr_i = '0;
    cmd_len_i = '0;
    cmd_write_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready_o", 64'(cmd_ready_o), 64'd0);
    check("reset_valid_o", 64'(cmd_valid_o), 64'd0);
    check("reset_outputs", 64'({cmd_addr_o, cmd_len_o, cmd_write_o, split_req_o}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(cmd_ready_o), 64'd1);
    @(negedge clk);

    // Table vectors, downstream always ready.
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      staged.delete();
      staged.push_back(vt[i].p0);
      if (vt[i].n == 2) staged.push_back(vt[i].p1);
      send(longint'(vt[i].addr), int'(vt[i].len), vt[i].write, tries);
      drain();
    end

    // Stall for 3 cycles while the first piece is held.
    cmd_ready_i = 1'b0;
    model(27'h03C, 8, 1'b0);
    send(27'h03C, 8, 1'b0, tries);
    idle(3);
    cmd_ready_i = 1'b1;
    drain();

    // Five back-to-back unsplit commands.
    cmd_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      model(longint'(27'h100 + i * 8), 4, i[0]);
      send(longint'(27'h100 + i * 8), 4, i[0], tries);
      check("b2b_tries", 64'(tries), 64'd1);
    end
    drain();

    // Reset while holding the first piece of a split.
    cmd_ready_i = 1'b0;
    model(27'h03C, 8, 1'b1);
    send(27'h03C, 8, 1'b1, tries);
    idle(1);
    rst_n = 1'b0;
    cmd_valid_i = 1'b0;
    #4;
    check("ready_in_reset", 64'(cmd_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    check("valid_after_rst", 64'(cmd_valid_o), 64'd0);
    check("split_after_rst", 64'(split_req_o), 64'd0);
    cmd_ready_i = 1'b1;
    idle(3);
    model(27'h13E, 5, 1'b0);
    send(27'h13E, 5, 1'b0, tries);
    drain();

    // Randomized commands with random downstream backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = longint'($urandom) % (longint'(1) << AW);
      if ($urandom_range(0, 1) == 1) a = a - (a % PW) + PW - longint'($urandom_range(1, 4));
      a = a % (longint'(1) << AW);
      l = int'($urandom_range(1, PW));
      model(a, l, 1'($urandom));
      send(a, l, staged[0].write, tries);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_ready = 1'b0;
    cmd_ready_i = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
